// File: rtl/ula_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// Each accepted operation owns the ALU until its response is taken.
module ula_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [3:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req1_op,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_result,
  output logic [2:0] rsp0_flags,
  output logic       rsp0_err,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_result,
  output logic [2:0] rsp1_flags,
  output logic       rsp1_err,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_negative,
  output logic       busy,
  output logic [1:0] o_dbg_state
);

  // Handshake: a beat moves on a rising edge where valid && ready; ready never
  // depends on anything but valid and the arbiter state, valid never on ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SHL  = 4'b0101;
  localparam logic [3:0] OP_SHR  = 4'b0110;
  localparam logic [3:0] OP_HOLD = 4'b1111;
  localparam logic [2:0] LAST_CNT = 3'(ALU_LAT);

  state_t     r_state;
  state_t     w_next;
  logic       r_ptr;
  logic [2:0] r_cnt;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [3:0] r_op;
  logic       r_id;
  logic [7:0] r_result;
  logic [2:0] r_flags;
  logic       r_err;

  logic       w_grant0;
  logic       w_grant1;
  logic       w_xfer;
  logic [7:0] w_sel_a;
  logic [7:0] w_sel_b;
  logic [3:0] w_sel_op;
  logic       w_legal;
  logic       w_exec_done;
  logic       w_rsp_hs;

  // The preferred requester wins if valid; otherwise the other one may take the slot.
  assign w_grant0 = (r_state == S_IDLE) && req0_valid && (!r_ptr || !req1_valid);
  assign w_grant1 = (r_state == S_IDLE) && req1_valid && ( r_ptr || !req0_valid);
  assign w_xfer   = w_grant0 || w_grant1;

  assign w_sel_a  = w_grant1 ? req1_a  : req0_a;
  assign w_sel_b  = w_grant1 ? req1_b  : req0_b;
  assign w_sel_op = w_grant1 ? req1_op : req0_op;
  assign w_legal  = (w_sel_op == OP_ADD) || (w_sel_op == OP_SUB) ||
                    (w_sel_op == OP_SHL) || (w_sel_op == OP_SHR);

  assign w_exec_done = (r_state == S_EXEC) && (r_cnt == LAST_CNT);
  assign w_rsp_hs    = (r_state == S_RESP) && (r_id ? rsp1_ready : rsp0_ready);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_xfer) w_next = w_legal ? S_EXEC : S_RESP;
      S_EXEC: if (w_exec_done) w_next = S_RESP;
      S_RESP: if (w_rsp_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= 1'b0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_id     <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_xfer) begin
        r_a   <= w_sel_a;
        r_b   <= w_sel_b;
        r_op  <= w_sel_op;
        r_id  <= w_grant1;
        r_ptr <= !w_grant1;
        r_cnt <= '0;
        if (!w_legal) begin
          r_result <= '0;
          r_flags  <= '0;
          r_err    <= 1'b1;
        end
      end
      if (r_state == S_EXEC) begin
        if (w_exec_done) begin
          r_cnt    <= '0;
          r_result <= alu_result;
          // Only subtraction reports a sign; other ops clear it.
          r_flags  <= {(r_op == OP_SUB) && alu_negative, alu_carry, alu_zero};
          r_err    <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  assign alu_a  = (r_state == S_EXEC) ? r_a  : '0;
  assign alu_b  = (r_state == S_EXEC) ? r_b  : '0;
  assign alu_op = (r_state == S_EXEC) ? r_op : OP_HOLD;

  assign rsp0_valid  = (r_state == S_RESP) && !r_id;
  assign rsp1_valid  = (r_state == S_RESP) &&  r_id;
  assign rsp0_result = rsp0_valid ? r_result : '0;
  assign rsp0_flags  = rsp0_valid ? r_flags  : '0;
  assign rsp0_err    = rsp0_valid && r_err;
  assign rsp1_result = rsp1_valid ? r_result : '0;
  assign rsp1_flags  = rsp1_valid ? r_flags  : '0;
  assign rsp1_err    = rsp1_valid && r_err;

  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule
